pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Instruction-fetch stage feeding IMEM and the decode stage. Holds the program
//   counter and drives it to IMEM as a word-aligned byte address. Captures IMEM's
//   combinational instruction word into an IF/ID register with a valid bit.
//   Supports decode-side stall and branch/jump redirect with wrong-path flush.
// PARAMETERS
//   PC_WIDTH_LENGTH    32            PC / address width
//   INST_WIDTH_LENGTH  32            instruction width
//   RESET_PC           32'h00000000  PC loaded on reset
//   TRAP_PC            32'h00000100  target on misaligned redirect (macro only)
//   NOP_INST           32'h00000013  bubble word (addi x0,x0,0)
// PORTS
//   clk           in   1    rising-edge clock
//   rst           in   1    synchronous, active-high reset
//   pc_o          out  32   fetch address to IMEM (PC input); bits [1:0] always 00
//   inst_i        in   32   instruction word returned combinationally by IMEM for pc_o
//   stall         in   1    decode not ready: hold PC and IF/ID
//   redirect      in   1    taken branch/jump resolved this cycle
//   redirect_pc   in   32   branch/jump target
//   id_pc         out  32   PC of instruction in IF/ID
//   id_inst       out  32   instruction in IF/ID
//   id_valid      out  1    IF/ID holds a real instruction
//   misalign_exc  out  1    1-cycle pulse: misaligned redirect trapped
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high; all state updates on rising clk.
//   - Reset values: pc_o=RESET_PC, id_pc=0, id_inst=NOP_INST, id_valid=0, misalign_exc=0.
//   - Edge priority: rst > redirect > stall > advance.
//   - Advance (no redirect, no stall): id_pc<=pc_o, id_inst<=inst_i, id_valid<=1,
//     pc_o<=pc_o+4. Fetch-to-decode latency 1 cycle; throughput 1 inst/cycle.
//   - Stall (no redirect): pc_o, id_pc, id_inst, id_valid all hold.
//   - Redirect (overrides stall): pc_o<=target; id_inst<=NOP_INST, id_valid<=0,
//     id_pc<=0 (squash wrong-path fetch); next instruction at target appears in IF/ID
//     one cycle after redirect deasserts with no stall.
//   - PC arithmetic modulo 2^32: 32'hFFFFFFFC + 4 -> 32'h00000000, no flag.
//   - pc_o[1:0] is always 2'b00, so IMEM never returns high-Z.
//   - Reset asserted mid-stream: state returns to reset values at that edge,
//     regardless of stall/redirect; first valid IF/ID appears one edge after rst drops.
//   - Without IF_MISALIGN_TRAP_EN, target = {redirect_pc[31:2],2'b00}.
//   - misalign_exc is a registered output, high only the cycle after a trap edge.
// CONFIGURATION
//   Macro IF_MISALIGN_TRAP_EN:
//   - defined: redirect with redirect_pc[1:0]!=0 -> pc_o<=TRAP_PC, flush as above,
//     misalign_exc=1 for exactly the following cycle. Aligned redirects unchanged.
//   - undefined: low bits silently cleared (target rule above); misalign_exc tied 0.
// TESTING
//   1 rst 2 cycles, release, IMEM words A0..A3 at 0x0..0xC -> pc_o 0,4,8,C;
//     id_inst A0 at first edge after release, id_valid=1, id_pc=0.
//   2 stall high 3 cycles at pc_o=0x8 -> pc_o,id_pc=0x4,id_inst frozen 3 cycles;
//     resume -> id_inst=word@0x8 next edge.
//   3 redirect=1, redirect_pc=0x40 while stall=1 -> next cycle pc_o=0x40, id_valid=0,
//     id_inst=0x00000013; following edge id_inst=word@0x40, id_pc=0x40.
//   4 rst high with pc_o=0x20 and redirect=1 -> pc_o=RESET_PC, id_valid=0, misalign_exc=0.
//   5 force pc to 0xFFFFFFFC via redirect -> next advance pc_o=0x00000000.
//   6 redirect_pc=0x42: with macro -> pc_o=0x100, misalign_exc=1 one cycle;
//     without macro -> pc_o=0x40, misalign_exc=0.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bundle: IMEM address/data, decode stall/redirect controls and IF/ID outputs.
// master = fetch unit, slave = IMEM/decode side.
interface pc_fetch_unit_if #(
  parameter int PC_WIDTH_LENGTH   = 32,
  parameter int INST_WIDTH_LENGTH = 32
);
  logic [PC_WIDTH_LENGTH-1:0]   pc_o;
  logic [INST_WIDTH_LENGTH-1:0] inst_i;
  logic                         stall;
  logic                         redirect;
  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc;
  logic [PC_WIDTH_LENGTH-1:0]   id_pc;
  logic [INST_WIDTH_LENGTH-1:0] id_inst;
  logic                         id_valid;
  logic                         misalign_exc;

  modport master (
    output pc_o, id_pc, id_inst, id_valid, misalign_exc,
    input  inst_i, stall, redirect, redirect_pc
  );

  modport slave (
    input  pc_o, id_pc, id_inst, id_valid, misalign_exc,
    output inst_i, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC -> IMEM, 1-cycle IF/ID register; stall holds all state, redirect wins and flushes.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirect goes to TRAP_PC and pulses misalign_exc.
module pc_fetch_unit #(
  parameter int                           PC_WIDTH_LENGTH   = 32,
  parameter int                           INST_WIDTH_LENGTH = 32,
  parameter logic [PC_WIDTH_LENGTH-1:0]   RESET_PC          = 32'h0000_0000,
  parameter logic [PC_WIDTH_LENGTH-1:0]   TRAP_PC           = 32'h0000_0100,
  parameter logic [INST_WIDTH_LENGTH-1:0] NOP_INST          = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  pc_fetch_unit_if.master  fif
);

  localparam int PCW = PC_WIDTH_LENGTH;
  localparam int IW  = INST_WIDTH_LENGTH;

  // Only the word index is stored, so the IMEM address can never be misaligned.
  logic [PCW-3:0] pc_q,       pc_d;
  logic [PCW-1:0] id_pc_q,    id_pc_d;
  logic [IW-1:0]  id_inst_q,  id_inst_d;
  logic           id_valid_q, id_valid_d;
  logic [PCW-3:0] target_word;
  logic           misalign_d;

  always_comb begin
    target_word = fif.redirect_pc[PCW-1:2];
    misalign_d  = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    if (fif.redirect && (fif.redirect_pc[1:0] != 2'b00)) begin
      target_word = TRAP_PC[PCW-1:2];
      misalign_d  = 1'b1;
    end
`endif
  end

  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (fif.redirect) begin
      // The word fetched this cycle is on the wrong path: replace it with a bubble.
      pc_d       = target_word;
      id_pc_d    = '0;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (!fif.stall) begin
      pc_d       = pc_q + 1'b1;
      id_pc_d    = {pc_q, 2'b00};
      id_inst_d  = fif.inst_i;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC[PCW-1:2];
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign fif.misalign_exc = misalign_q;
`else
  assign fif.misalign_exc = 1'b0;
`endif

  assign fif.pc_o     = {pc_q, 2'b00};
  assign fif.id_pc    = id_pc_q;
  assign fif.id_inst  = id_inst_q;
  assign fif.id_valid = id_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, advance, stall, redirect/flush, reset priority, wrap, misaligned redirect.
module tb_pc_fetch_unit;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  pc_fetch_unit_if #(.PC_WIDTH_LENGTH(32), .INST_WIDTH_LENGTH(32)) fif ();

  pc_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IMEM model: every word is a recognisable function of its byte address.
  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return 32'hC0DE_0000 ^ addr;
  endfunction

  assign fif.inst_i = word_at(fif.pc_o);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    n_chk           = 0;
    n_fail          = 0;
    rst             = 1'b1;
    fif.stall       = 1'b0;
    fif.redirect    = 1'b0;
    fif.redirect_pc = 32'h0;

    // Reset state
    step();
    step();
    chk("rst_pc",       fif.pc_o,                32'h0);
    chk("rst_id_pc",    fif.id_pc,               32'h0);
    chk("rst_id_inst",  fif.id_inst,             NOP);
    chk("rst_id_valid", {31'b0, fif.id_valid},   32'h0);
    chk("rst_misalign", {31'b0, fif.misalign_exc}, 32'h0);

    // Advance from reset
    rst = 1'b0;
    step();
    chk("adv0_pc",      fif.pc_o,              32'h4);
    chk("adv0_id_inst", fif.id_inst,           word_at(32'h0));
    chk("adv0_id_pc",   fif.id_pc,             32'h0);
    chk("adv0_valid",   {31'b0, fif.id_valid}, 32'h1);
    step();
    chk("adv1_pc",      fif.pc_o,    32'h8);
    chk("adv1_id_inst", fif.id_inst, word_at(32'h4));

    // Stall at pc 0x8 for three edges
    fif.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc",      fif.pc_o,              32'h8);
      chk("stall_id_pc",   fif.id_pc,             32'h4);
      chk("stall_id_inst", fif.id_inst,           word_at(32'h4));
      chk("stall_valid",   {31'b0, fif.id_valid}, 32'h1);
    end
    fif.stall = 1'b0;
    step();
    chk("resume_id_inst", fif.id_inst, word_at(32'h8));
    chk("resume_id_pc",   fif.id_pc,   32'h8);
    chk("resume_pc",      fif.pc_o,    32'hC);

    // Redirect overrides stall and flushes IF/ID
    fif.stall       = 1'b1;
    fif.redirect    = 1'b1;
    fif.redirect_pc = 32'h40;
    step();
    chk("redir_pc",      fif.pc_o,              32'h40);
    chk("redir_valid",   {31'b0, fif.id_valid}, 32'h0);
    chk("redir_id_inst", fif.id_inst,           NOP);
    chk("redir_id_pc",   fif.id_pc,             32'h0);
    fif.stall    = 1'b0;
    fif.redirect = 1'b0;
    step();
    chk("tgt_id_inst", fif.id_inst,           word_at(32'h40));
    chk("tgt_id_pc",   fif.id_pc,             32'h40);
    chk("tgt_valid",   {31'b0, fif.id_valid}, 32'h1);
    chk("tgt_pc",      fif.pc_o,              32'h44);

    // Reset wins over a concurrent redirect
    fif.redirect    = 1'b1;
    fif.redirect_pc = 32'h20;
    step();
    chk("pre_rst_pc", fif.pc_o, 32'h20);
    rst             = 1'b1;
    fif.redirect_pc = 32'h80;
    step();
    chk("midrst_pc",       fif.pc_o,                  32'h0);
    chk("midrst_valid",    {31'b0, fif.id_valid},     32'h0);
    chk("midrst_id_inst",  fif.id_inst,               NOP);
    chk("midrst_misalign", {31'b0, fif.misalign_exc}, 32'h0);
    rst          = 1'b0;
    fif.redirect = 1'b0;
    step();
    chk("postrst_valid",   {31'b0, fif.id_valid}, 32'h1);
    chk("postrst_id_inst", fif.id_inst,           word_at(32'h0));
    chk("postrst_pc",      fif.pc_o,              32'h4);

    // PC wraps modulo 2^32
    fif.redirect    = 1'b1;
    fif.redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("top_pc", fif.pc_o, 32'hFFFF_FFFC);
    fif.redirect = 1'b0;
    step();
    chk("wrap_pc",      fif.pc_o,    32'h0);
    chk("wrap_id_pc",   fif.id_pc,   32'hFFFF_FFFC);
    chk("wrap_id_inst", fif.id_inst, word_at(32'hFFFF_FFFC));

    // Misaligned redirect target
    fif.redirect    = 1'b1;
    fif.redirect_pc = 32'h42;
    step();
`ifdef IF_MISALIGN_TRAP_EN
    chk("mis_pc",       fif.pc_o,                  32'h100);
    chk("mis_exc",      {31'b0, fif.misalign_exc}, 32'h1);
    chk("mis_valid",    {31'b0, fif.id_valid},     32'h0);
    fif.redirect = 1'b0;
    step();
    chk("mis_exc_drop", {31'b0, fif.misalign_exc}, 32'h0);
    chk("mis_id_inst",  fif.id_inst,               word_at(32'h100));
    chk("mis_next_pc",  fif.pc_o,                  32'h104);
`else
    chk("mis_pc",       fif.pc_o,                  32'h40);
    chk("mis_exc",      {31'b0, fif.misalign_exc}, 32'h0);
    chk("mis_valid",    {31'b0, fif.id_valid},     32'h0);
    fif.redirect = 1'b0;
    step();
    chk("mis_exc_after", {31'b0, fif.misalign_exc}, 32'h0);
    chk("mis_id_inst",   fif.id_inst,               word_at(32'h40));
    chk("mis_next_pc",   fif.pc_o,                  32'h44);
`endif

    // Aligned redirect never raises the exception
    fif.redirect    = 1'b1;
    fif.redirect_pc = 32'h200;
    step();
    fif.redirect = 1'b0;
    chk("align_pc",  fif.pc_o,                  32'h200);
    chk("align_exc", {31'b0, fif.misalign_exc}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
